// File: rtl/res_ram_sched_pkg.sv
// Shared definitions for the result-RAM write-back scheduler: controller states,
// burst geometry and a small state-classification helper.
package res_ram_sched_pkg;

    localparam int unsigned WORDS_PER_BURST = 4;
    localparam int unsigned BURSTS_DEFAULT  = 16;
    localparam int unsigned BEAT_W          = $clog2(WORDS_PER_BURST);
    localparam int unsigned BURST_CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic logic is_active(input state_e s);
        return (s == RUN) || (s == BURST);
    endfunction

endpackage

// File: rtl/res_ram_sched_if.sv
// Signal bundle between the scheduler, the MU write-back block, the host read port
// and the single-port result RAM. The scheduler is the master side.
interface res_ram_sched_if;

    logic        start;
    logic        mu_valid;
    logic        web;
    logic        wb_we_n;
    logic [7:0]  wb_addr;
    logic [31:0] wb_data;
    logic        host_req;
    logic [7:0]  host_addr;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic        ram_cs_n;
    logic        ram_we_n;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  start, mu_valid, wb_we_n, wb_addr, wb_data, host_req, host_addr, ram_rdata,
        output web, host_gnt, host_rvalid, host_rdata, ram_cs_n, ram_we_n, ram_addr,
               ram_wdata, busy, done, err
    );

    modport slave (
        output start, mu_valid, wb_we_n, wb_addr, wb_data, host_req, host_addr, ram_rdata,
        input  web, host_gnt, host_rvalid, host_rdata, ram_cs_n, ram_we_n, ram_addr,
               ram_wdata, busy, done, err
    );

endinterface

// File: rtl/res_ram_sched.sv
// Schedules MU result write-back bursts into the result RAM and arbitrates the
// remaining RAM cycles to host reads; write-back always wins the port.
module res_ram_sched
    import res_ram_sched_pkg::*;
#(
    parameter int unsigned BURSTS = BURSTS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    res_ram_sched_if.master bus
);

    localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(WORDS_PER_BURST - 1);
    localparam logic [BURST_CNT_W:0] BURSTS_EXT = (BURST_CNT_W + 1)'(BURSTS);
    localparam logic [BURST_CNT_W:0] CNT_ONE    = (BURST_CNT_W + 1)'(1);
    localparam logic [BEAT_W-1:0]    BEAT_ONE   = BEAT_W'(1);

    state_e                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic                   web_q, web_d;
    logic                   err_q, err_d;
    logic                   rvalid_q;
    logic                   issue;
    logic                   host_gnt;
    logic [BURST_CNT_W:0]   burst_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            burst_cnt_q <= '0;
            beat_q      <= '0;
            web_q       <= 1'b0;
            err_q       <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            burst_cnt_q <= burst_cnt_d;
            beat_q      <= beat_d;
            web_q       <= web_d;
            err_q       <= err_d;
            rvalid_q    <= host_gnt;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        burst_cnt_d = burst_cnt_q;
        beat_d      = beat_q;
        web_d       = 1'b0;
        err_d       = err_q;
        issue       = 1'b0;
        burst_inc   = {1'b0, burst_cnt_q} + CNT_ONE;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    pending_d   = 1'b0;
                    burst_cnt_d = '0;
                    err_d       = 1'b0;
                end else if (bus.mu_valid) begin
                    err_d = 1'b1;
                end
            end
            RUN: begin
                issue = pending_q | bus.mu_valid;
            end
            BURST: begin
                if (beat_q == LAST_BEAT) begin
                    if (burst_inc >= BURSTS_EXT) begin
                        burst_cnt_d = BURSTS_EXT[BURST_CNT_W-1:0];
                        state_d     = DONE;
                    end else begin
                        burst_cnt_d = burst_inc[BURST_CNT_W-1:0];
                        // A waiting result chains straight into the next burst with no gap cycle.
                        if (pending_q || bus.mu_valid) begin
                            issue = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end else begin
                    beat_d = beat_q + BEAT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            web_d   = 1'b1;
            state_d = BURST;
            beat_d  = '0;
        end

        // An issue consumes the oldest waiting result; a second unconsumed one is an overrun.
        if (is_active(state_q)) begin
            if (issue) begin
                pending_d = pending_q & bus.mu_valid;
            end else begin
                pending_d = pending_q | bus.mu_valid;
                if (pending_q && bus.mu_valid) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    assign host_gnt        = bus.host_req & ~web_q & (state_q != BURST);

    assign bus.web         = web_q;
    assign bus.busy        = is_active(state_q) | web_q;
    assign bus.done        = (state_q == DONE);
    assign bus.err         = err_q;
    assign bus.host_gnt    = host_gnt;
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_rdata  = rvalid_q ? bus.ram_rdata : '0;

    assign bus.ram_we_n    = bus.wb_we_n;
    assign bus.ram_addr    = bus.wb_we_n ? bus.host_addr : bus.wb_addr;
    assign bus.ram_wdata   = bus.wb_we_n ? '0 : bus.wb_data;
    assign bus.ram_cs_n    = ~(~bus.wb_we_n | host_gnt);

endmodule
